port_ring_tap_arb: RTL and testbench

Parametrised next-generation ring tap for the bridge example. It sits between one local port (flow-list FIFO, port RX FIFO, port TX FIFO) and the ring in/out links. It injects local packets on the ring with a destination-vector header, and it forwards, copies or sinks ring packets by destination vector. New over the previous tap:
- generic port count and payload width
- round-robin fairness between local injection and ring traffic
- correct last-port sink path
- drain of undeliverable packets
- saturating per-path packet counters

---
 rtl/port_ring_tap_arb_pkg.sv | 48 ++++
 rtl/port_ring_sat_cnt.sv | 23 ++
 rtl/port_ring_tap_arb.sv | 184 ++++++++++++++++++
 tb/tb_port_ring_tap_arb.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/port_ring_tap_arb_pkg.sv
// rtl/port_ring_tap_arb_pkg.sv - shared pcc codes, ring-word field positions and state indices for the ring tap
package port_ring_tap_arb_pkg;

    localparam logic [1:0] pcc_data   = 2'd0;
    localparam logic [1:0] pcc_sop    = 2'd1;
    localparam logic [1:0] pcc_eop    = 2'd2;
    localparam logic [1:0] pcc_badeop = 2'd3;

    localparam int st_idle    = 0;
    localparam int st_tdata   = 1;
    localparam int st_rfwd    = 2;
    localparam int st_rcopy   = 3;
    localparam int st_rsink   = 4;
    localparam int st_ldrop   = 5;
    localparam int st_rdrop   = 6;
    localparam int num_states = 7;

    localparam logic [num_states-1:0] s_idle  = 7'b000_0001;
    localparam logic [num_states-1:0] s_tdata = 7'b000_0010;
    localparam logic [num_states-1:0] s_rfwd  = 7'b000_0100;
    localparam logic [num_states-1:0] s_rcopy = 7'b000_1000;
    localparam logic [num_states-1:0] s_rsink = 7'b001_0000;
    localparam logic [num_states-1:0] s_ldrop = 7'b010_0000;
    localparam logic [num_states-1:0] s_rdrop = 7'b100_0000;

    typedef enum logic {
        prio_local = 1'b0,
        prio_ring  = 1'b1
    } prio_e;

    // Ring word layout is {pvec, pcc[1:0], payload[dw-1:0]}
    function automatic int prw_pvec(input int dw);
        return dw + 2;
    endfunction

    function automatic int prw_pcc_lo(input int dw);
        return dw;
    endfunction

    function automatic int prw_data_hi(input int dw);
        return dw - 1;
    endfunction

    function automatic logic is_end(input logic [1:0] pcc);
        return (pcc == pcc_eop) || (pcc == pcc_badeop);
    endfunction

endpackage

// File: rtl/port_ring_sat_cnt.sv
// rtl/port_ring_sat_cnt.sv - saturating packet counter with synchronous reset
module port_ring_sat_cnt #(
    parameter int cnt_w = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [cnt_w-1:0] count_o
);

    logic [cnt_w-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + {{(cnt_w-1){1'b0}}, 1'b1};
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/port_ring_tap_arb.sv
// rtl/port_ring_tap_arb.sv - ring tap: injects local packets, forwards/copies/sinks/drops ring packets by destination vector
module port_ring_tap_arb
    import port_ring_tap_arb_pkg::*;
#(
    parameter int num_ports = 4,
    parameter int portnum   = 0,
    parameter int dw        = 62,
    parameter int pdp_sz    = dw + 2,
    parameter int rdp_sz    = dw + 3,
    parameter int cnt_w     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [num_ports-1:0] lfli_data,
    input  logic                 lfli_srdy,
    output logic                 lfli_drdy,
    input  logic [pdp_sz-1:0]    lprx_data,
    input  logic                 lprx_srdy,
    output logic                 lprx_drdy,
    output logic [pdp_sz-1:0]    lptx_data,
    output logic                 lptx_srdy,
    input  logic                 lptx_drdy,
    input  logic [rdp_sz-1:0]    lri_data,
    input  logic                 lri_srdy,
    output logic                 lri_drdy,
    output logic [rdp_sz-1:0]    lro_data,
    output logic                 lro_srdy,
    input  logic                 lro_drdy,
    output logic                 proto_err,
    output logic [cnt_w-1:0]     cnt_inj,
    output logic [cnt_w-1:0]     cnt_fwd,
    output logic [cnt_w-1:0]     cnt_rx,
    output logic [cnt_w-1:0]     cnt_drop
);

    localparam int pvec_b = prw_pvec(dw);
    localparam int pcc_lo = prw_pcc_lo(dw);
    localparam logic [num_ports-1:0] own = {{(num_ports-1){1'b0}}, 1'b1} << portnum;

    logic [num_states-1:0] state_q, state_d;
    prio_e                 prio_q, prio_d;
    logic                  inc_inj, inc_fwd, inc_rx, inc_drop;

    logic [num_ports-1:0] lv, rv, rest;
    logic                 ri_pvec, sel_local, sel_ring, ri_done, lp_done;
    logic [1:0]           ri_pcc, lp_pcc;
    logic [rdp_sz-1:0]    hdr;

    assign lv        = lfli_data & ~own;
    assign rv        = lri_data[num_ports-1:0];
    assign rest      = rv & ~own;
    assign ri_pvec   = lri_data[pvec_b];
    assign ri_pcc    = lri_data[pcc_lo+1:pcc_lo];
    assign lp_pcc    = lprx_data[pcc_lo+1:pcc_lo];
    assign sel_local = lfli_srdy && (!lri_srdy || (prio_q == prio_local));
    assign sel_ring  = lri_srdy && !sel_local;
    assign ri_done   = lri_srdy && lri_drdy && is_end(ri_pcc);
    assign lp_done   = lprx_srdy && lprx_drdy && is_end(lp_pcc);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= s_idle;
            prio_q  <= prio_local;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Transitions key off the pops issued by the output process, so a start is taken exactly when its word is consumed
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        inc_inj  = 1'b0;
        inc_fwd  = 1'b0;
        inc_rx   = 1'b0;
        inc_drop = 1'b0;
        if (state_q[st_idle]) begin
            if (lfli_drdy) begin
                prio_d   = prio_ring;
                state_d  = (lv != '0) ? s_tdata : s_ldrop;
                inc_inj  = (lv != '0);
                inc_drop = (lv == '0);
            end else if (lri_drdy && ri_pvec) begin
                prio_d = prio_local;
                if ((rv & own) != '0) begin
                    state_d = (rest != '0) ? s_rcopy : s_rsink;
                end else if (rv != '0) begin
                    state_d = s_rfwd;
                end else begin
                    state_d  = s_rdrop;
                    inc_drop = 1'b1;
                end
            end
        end else if (state_q[st_tdata] || state_q[st_ldrop]) begin
            if (lp_done) begin
                state_d = s_idle;
            end
        end else if (ri_done) begin
            state_d = s_idle;
            inc_fwd = state_q[st_rfwd];
            inc_rx  = state_q[st_rcopy] || state_q[st_rsink];
        end
    end

    always_comb begin
        lfli_drdy = 1'b0;
        lprx_drdy = 1'b0;
        lptx_srdy = 1'b0;
        lptx_data = lri_data[pdp_sz-1:0];
        lri_drdy  = 1'b0;
        lro_srdy  = 1'b0;
        lro_data  = lri_data;
        proto_err = 1'b0;
        hdr       = '0;
        hdr[pvec_b] = 1'b1;
        if (!reset) begin
            if (state_q[st_idle]) begin
                if (sel_local) begin
                    if (lv != '0) begin
                        hdr[num_ports-1:0] = lv;
                        lro_data  = hdr;
                        lro_srdy  = 1'b1;
                        lfli_drdy = lro_drdy;
                    end else begin
                        lfli_drdy = 1'b1;
                    end
                end else if (sel_ring) begin
                    if (!ri_pvec) begin
                        lri_drdy  = 1'b1;
                        proto_err = 1'b1;
                    end else if ((rv & own) != '0) begin
                        if (rest != '0) begin
                            hdr[num_ports-1:0] = rest;
                            lro_data = hdr;
                            lro_srdy = 1'b1;
                            lri_drdy = lro_drdy;
                        end else begin
                            lri_drdy = 1'b1;
                        end
                    end else if (rv != '0) begin
                        lro_srdy = 1'b1;
                        lri_drdy = lro_drdy;
                    end else begin
                        lri_drdy = 1'b1;
                    end
                end
            end else if (state_q[st_tdata]) begin
                lro_data  = {1'b0, lprx_data};
                lro_srdy  = lprx_srdy;
                lprx_drdy = lro_drdy;
            end else if (state_q[st_rfwd]) begin
                lro_srdy = lri_srdy;
                lri_drdy = lro_drdy;
            end else if (state_q[st_rcopy]) begin
                // Each side only sees valid when every other party is ready, so a word moves everywhere or nowhere
                lro_srdy  = lri_srdy && lptx_drdy;
                lptx_srdy = lri_srdy && lro_drdy;
                lri_drdy  = lro_drdy && lptx_drdy;
            end else if (state_q[st_rsink]) begin
                lptx_srdy = lri_srdy;
                lri_drdy  = lptx_drdy;
            end else if (state_q[st_ldrop]) begin
                lprx_drdy = 1'b1;
            end else if (state_q[st_rdrop]) begin
                lri_drdy = 1'b1;
            end
        end
    end

    port_ring_sat_cnt #(.cnt_w(cnt_w)) u_cnt_inj (
        .clk(clk), .reset(reset), .inc_i(inc_inj), .count_o(cnt_inj)
    );
    port_ring_sat_cnt #(.cnt_w(cnt_w)) u_cnt_fwd (
        .clk(clk), .reset(reset), .inc_i(inc_fwd), .count_o(cnt_fwd)
    );
    port_ring_sat_cnt #(.cnt_w(cnt_w)) u_cnt_rx (
        .clk(clk), .reset(reset), .inc_i(inc_rx), .count_o(cnt_rx)
    );
    port_ring_sat_cnt #(.cnt_w(cnt_w)) u_cnt_drop (
        .clk(clk), .reset(reset), .inc_i(inc_drop), .count_o(cnt_drop)
    );

endmodule

// File: tb/tb_port_ring_tap_arb.sv
// tb/tb_port_ring_tap_arb.sv - directed self-checking bench for port_ring_tap_arb
module tb_port_ring_tap_arb;

    localparam int np  = 4;
    localparam int dw  = 8;
    localparam int pdp = dw + 2;
    localparam int rdp = dw + 3;
    localparam int cw  = 2;
    localparam logic [1:0] c_data = 2'd0, c_sop = 2'd1, c_eop = 2'd2, c_bad = 2'd3;

    logic           clk = 1'b0;
    logic           reset;
    logic [np-1:0]  lfli_data;
    logic           lfli_srdy, lfli_drdy;
    logic [pdp-1:0] lprx_data, lptx_data;
    logic           lprx_srdy, lprx_drdy, lptx_srdy, lptx_drdy;
    logic [rdp-1:0] lri_data, lro_data;
    logic           lri_srdy, lri_drdy, lro_srdy, lro_drdy;
    logic           proto_err;
    logic [cw-1:0]  cnt_inj, cnt_fwd, cnt_rx, cnt_drop;
    logic [5:0]     hs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign hs = {lfli_drdy, lprx_drdy, lptx_srdy, lri_drdy, lro_srdy, proto_err};

    port_ring_tap_arb #(
        .num_ports(np), .portnum(0), .dw(dw), .pdp_sz(pdp), .rdp_sz(rdp), .cnt_w(cw)
    ) dut (
        .clk(clk), .reset(reset),
        .lfli_data(lfli_data), .lfli_srdy(lfli_srdy), .lfli_drdy(lfli_drdy),
        .lprx_data(lprx_data), .lprx_srdy(lprx_srdy), .lprx_drdy(lprx_drdy),
        .lptx_data(lptx_data), .lptx_srdy(lptx_srdy), .lptx_drdy(lptx_drdy),
        .lri_data(lri_data), .lri_srdy(lri_srdy), .lri_drdy(lri_drdy),
        .lro_data(lro_data), .lro_srdy(lro_srdy), .lro_drdy(lro_drdy),
        .proto_err(proto_err),
        .cnt_inj(cnt_inj), .cnt_fwd(cnt_fwd), .cnt_rx(cnt_rx), .cnt_drop(cnt_drop)
    );

    function automatic logic [rdp-1:0] rw(input logic pv, input logic [1:0] pcc, input logic [7:0] pl);
        return {pv, pcc, pl};
    endfunction

    function automatic logic [pdp-1:0] pw(input logic [1:0] pcc, input logic [7:0] pl);
        return {pcc, pl};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        lfli_srdy = 1'b0; lprx_srdy = 1'b0; lri_srdy = 1'b0;
        lfli_data = '0;   lprx_data = '0;   lri_data = '0;
        lro_drdy  = 1'b1; lptx_drdy = 1'b1;
    endtask

    task automatic test_reset();
        quiet();
        reset = 1'b1;
        lfli_srdy = 1'b1; lfli_data = 4'b0110; lprx_srdy = 1'b1;
        lri_srdy = 1'b1; lri_data = rw(1'b0, c_data, 8'h00);
        tick(); #1;
        checks++; if (hs !== 6'b000000) begin errors++; $display("FAIL reset_hs: got %b want 000000", hs); end
        checks++; if ({cnt_inj, cnt_fwd, cnt_rx, cnt_drop} !== 8'h00) begin errors++;
            $display("FAIL reset_cnt: got %h want 00", {cnt_inj, cnt_fwd, cnt_rx, cnt_drop}); end
        reset = 1'b0;
        quiet();
        tick();
    endtask

    task automatic test_local_inject();
        logic [1:0] pccs [3];
        pccs[0] = c_sop; pccs[1] = c_data; pccs[2] = c_eop;
        lfli_data = 4'b0110; lfli_srdy = 1'b1; #1;
        checks++; if (lro_data !== 11'h406) begin errors++; $display("FAIL inj_hdr: got %h want 406", lro_data); end
        checks++; if (hs !== 6'b100010) begin errors++; $display("FAIL inj_hdr_hs: got %b want 100010", hs); end
        tick();
        lfli_srdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lprx_data = pw(pccs[i], 8'hA1 + 8'(i)); lprx_srdy = 1'b1; #1;
            checks++; if (lro_data !== {1'b0, lprx_data} || hs !== 6'b010010) begin errors++;
                $display("FAIL inj_body%0d: got %h/%b want %h/010010", i, lro_data, hs, {1'b0, lprx_data}); end
            tick();
        end
        quiet(); #1;
        checks++; if (cnt_inj !== 2'd1) begin errors++; $display("FAIL inj_cnt: got %0d want 1", cnt_inj); end
        checks++; if (hs !== 6'b000000) begin errors++; $display("FAIL inj_idle_hs: got %b want 000000", hs); end
    endtask

    task automatic test_ring_copy();
        lri_data = rw(1'b1, c_data, 8'h03); lri_srdy = 1'b1; #1;
        checks++; if (lro_data !== 11'h402 || hs !== 6'b000110) begin errors++;
            $display("FAIL copy_hdr: got %h/%b want 402/000110", lro_data, hs); end
        tick();
        lri_data = rw(1'b0, c_sop, 8'h11); #1;
        checks++; if (hs !== 6'b001110 || lro_data !== 11'h111 || lptx_data !== 10'h111) begin errors++;
            $display("FAIL copy_w0: got %b/%h/%h want 001110/111/111", hs, lro_data, lptx_data); end
        tick();
        lri_data = rw(1'b0, c_data, 8'h12); lptx_drdy = 1'b0; #1;
        checks++; if (hs !== 6'b001000) begin errors++; $display("FAIL copy_stall: got %b want 001000", hs); end
        tick();
        lptx_drdy = 1'b1; #1;
        checks++; if (hs !== 6'b001110 || lptx_data !== 10'h012) begin errors++;
            $display("FAIL copy_resume: got %b/%h want 001110/012", hs, lptx_data); end
        tick();
        lri_data = rw(1'b0, c_eop, 8'h13);
        tick();
        quiet(); #1;
        checks++; if (cnt_rx !== 2'd1) begin errors++; $display("FAIL copy_cnt: got %0d want 1", cnt_rx); end
    endtask

    task automatic test_ring_sink();
        lri_data = rw(1'b1, c_data, 8'h01); lri_srdy = 1'b1; #1;
        checks++; if (hs !== 6'b000100) begin errors++; $display("FAIL sink_hdr: got %b want 000100", hs); end
        tick();
        lri_data = rw(1'b0, c_sop, 8'h21); #1;
        checks++; if (hs !== 6'b001100 || lptx_data !== 10'h121) begin errors++;
            $display("FAIL sink_w0: got %b/%h want 001100/121", hs, lptx_data); end
        tick();
        lri_data = rw(1'b0, c_bad, 8'h22); #1;
        checks++; if (hs !== 6'b001100 || lptx_data !== 10'h322) begin errors++;
            $display("FAIL sink_bad: got %b/%h want 001100/322", hs, lptx_data); end
        tick();
        lri_data = rw(1'b1, c_data, 8'h04); #1;
        checks++; if (hs !== 6'b000110 || lro_data !== 11'h404) begin errors++;
            $display("FAIL fwd_hdr: got %b/%h want 000110/404", hs, lro_data); end
        tick();
        lri_data = rw(1'b0, c_eop, 8'h31); #1;
        checks++; if (hs !== 6'b000110 || lro_data !== 11'h231) begin errors++;
            $display("FAIL fwd_body: got %b/%h want 000110/231", hs, lro_data); end
        tick();
        quiet(); #1;
        checks++; if (cnt_rx !== 2'd2 || cnt_fwd !== 2'd1) begin errors++;
            $display("FAIL sink_cnt: got rx=%0d fwd=%0d want rx=2 fwd=1", cnt_rx, cnt_fwd); end
    endtask

    task automatic test_round_robin();
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lfli_data = 4'b0010; lfli_srdy = 1'b1;
            lprx_data = pw(c_eop, 8'(i)); lprx_srdy = 1'b1;
            lri_data = rw(1'b1, c_data, 8'h04); lri_srdy = 1'b1; #1;
            checks++; if ({lfli_drdy, lri_drdy} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++;
                $display("FAIL rr_pick%0d: got %b want %b", i, {lfli_drdy, lri_drdy}, (i % 2 == 0) ? 2'b10 : 2'b01); end
            tick();
            if (i % 2 == 1) lri_data = rw(1'b0, c_eop, 8'(i));
            tick();
        end
        quiet(); #1;
        checks++; if (cnt_inj !== 2'd2 || cnt_fwd !== 2'd2) begin errors++;
            $display("FAIL rr_cnt: got inj=%0d fwd=%0d want 2/2", cnt_inj, cnt_fwd); end
    endtask

    task automatic test_drop();
        logic [1:0] pccs [3];
        pccs[0] = c_sop; pccs[1] = c_data; pccs[2] = c_eop;
        lfli_data = 4'b0001; lfli_srdy = 1'b1; #1;
        checks++; if (hs !== 6'b100000) begin errors++; $display("FAIL ldrop_start: got %b want 100000", hs); end
        tick();
        lfli_srdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lprx_data = pw(pccs[i], 8'h40); lprx_srdy = 1'b1; #1;
            checks++; if (hs !== 6'b010000) begin errors++; $display("FAIL ldrop_w%0d: got %b want 010000", i, hs); end
            tick();
        end
        quiet(); #1;
        checks++; if (cnt_drop !== 2'd1) begin errors++; $display("FAIL ldrop_cnt: got %0d want 1", cnt_drop); end
        lri_data = rw(1'b1, c_data, 8'h00); lri_srdy = 1'b1; #1;
        checks++; if (hs !== 6'b000100) begin errors++; $display("FAIL rdrop_start: got %b want 000100", hs); end
        tick();
        lri_data = rw(1'b0, c_sop, 8'h50); #1;
        checks++; if (hs !== 6'b000100) begin errors++; $display("FAIL rdrop_w0: got %b want 000100", hs); end
        tick();
        lri_data = rw(1'b0, c_eop, 8'h51);
        tick();
        lri_data = rw(1'b0, c_data, 8'h55); #1;
        checks++; if (hs !== 6'b000101) begin errors++; $display("FAIL proto_err: got %b want 000101", hs); end
        tick();
        quiet(); #1;
        checks++; if (hs !== 6'b000000 || cnt_drop !== 2'd2) begin errors++;
            $display("FAIL rdrop_end: got %b/%0d want 000000/2", hs, cnt_drop); end
    endtask

    task automatic test_reset_mid();
        lri_data = rw(1'b1, c_data, 8'h03); lri_srdy = 1'b1;
        tick();
        lri_data = rw(1'b0, c_sop, 8'h61);
        tick();
        lri_data = rw(1'b0, c_data, 8'h62); reset = 1'b1; #1;
        checks++; if (hs !== 6'b000000) begin errors++; $display("FAIL midrst_hs: got %b want 000000", hs); end
        tick();
        reset = 1'b0; lri_data = rw(1'b0, c_data, 8'h66); #1;
        checks++; if (hs !== 6'b000101) begin errors++; $display("FAIL midrst_idle: got %b want 000101", hs); end
        checks++; if ({cnt_inj, cnt_fwd, cnt_rx, cnt_drop} !== 8'h00) begin errors++;
            $display("FAIL midrst_cnt: got %h want 00", {cnt_inj, cnt_fwd, cnt_rx, cnt_drop}); end
        tick();
        quiet();
    endtask

    task automatic test_saturation();
        for (int k = 1; k <= 4; k++) begin
            lri_data = rw(1'b1, c_data, 8'h08); lri_srdy = 1'b1;
            tick();
            lri_data = rw(1'b0, c_eop, 8'(k));
            tick();
            quiet(); #1;
            checks++; if (cnt_fwd !== ((k > 3) ? 2'd3 : 2'(k))) begin errors++;
                $display("FAIL sat_fwd%0d: got %0d want %0d", k, cnt_fwd, (k > 3) ? 3 : k); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_local_inject();
        test_ring_copy();
        test_ring_sink();
        test_round_robin();
        test_drop();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
